instr_fetch: RTL and testbench

Instruction fetch stage for the 19-bit `cpu19` core. It sits upstream of the instruction register and `control_unit`. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Returned words go into a small prefetch buffer, and the stage presents them downstream with a valid/ready handshake. It also takes branch/jump redirects from execute, flushing the buffer and discarding any read already in flight.

---
 rtl/instr_fetch_if.sv | 45 ++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory read port, the execute-stage redirect and the
// downstream instruction handshake of the cpu19 fetch stage.
interface instr_fetch_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// cpu19 instruction fetch: owns the PC, issues single-outstanding imem reads,
// buffers returned words and hands them downstream; redirects flush and drain.
module instr_fetch #(
    parameter int                 DATA_W   = 19,
    parameter int                 ADDR_W   = 19,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 DEPTH    = 2
) (
    input  logic           clk,
    input  logic           reset,
    instr_fetch_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];

    logic req;
    logic push;
    logic pop;

    // Request depends only on registered state, so it cannot drop once raised
    // in FETCH: pops can only lower the count.
    assign req  = ((state_q == S_FETCH) && (count_q < DEPTH_C)) || (state_q == S_DRAIN);
    assign push = (state_q == S_FETCH) && req && bus.imem_ack;
    assign pop  = bus.instr_valid && bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = data_q[head_q];
    assign bus.instr_pc    = pc_q[head_q];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        data_d       = data_q;
        pc_d         = pc_q;

        if (bus.redirect_valid) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.redirect_pc;
            if (state_q == S_DRAIN) begin
                state_d = bus.imem_ack ? S_FETCH : S_DRAIN;
            end else if (req && !bus.imem_ack) begin
                // Abandoned read must still complete at its original address.
                state_d      = S_DRAIN;
                drain_addr_d = fetch_pc_q;
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: state_d = S_FETCH;
                S_DRAIN: state_d = bus.imem_ack ? S_FETCH : S_DRAIN;
                default: state_d = S_IDLE;
            endcase

            if (push) begin
                data_d[tail_q] = bus.imem_rdata;
                pc_d[tail_q]   = fetch_pc_q;
                tail_d         = tail_q + PTR_W'(1);
                fetch_pc_d     = fetch_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder with variable latency, directed
// scenarios plus random traffic, and a scoreboard of the expected PC stream.
module tb_instr_fetch;
    localparam logic [18:0] RESET_PC = 19'h0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.DATA_W(19), .ADDR_W(19)) bus ();

    instr_fetch #(
        .DATA_W(19),
        .ADDR_W(19),
        .RESET_PC(RESET_PC),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int deliveries = 0;
    int acks = 0;

    // Expected program stream: consecutive PCs from the last reset/redirect target.
    logic [18:0] exp_q[$];
    logic [18:0] tail_pc;

    // Memory model state
    bit busy = 0;
    int lat = 0;
    int lat_mode = 0;

    function automatic logic [18:0] mem_word(input logic [18:0] a);
        return a + 19'h100;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic reload(input logic [18:0] pc);
        exp_q.delete();
        tail_pc = pc;
        repeat (8) begin
            exp_q.push_back(tail_pc);
            tail_pc = tail_pc + 19'd1;
        end
    endtask

    // One clock: the edge consumes the inputs set last cycle, then memory responds.
    task automatic step();
        @(posedge clk);
        if (reset) reload(RESET_PC);
        else if (bus.redirect_valid) reload(bus.redirect_pc);
        #1;
        if (reset || !bus.imem_req) begin
            bus.imem_ack = 1'b0;
            busy = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (lat == 0) begin
                bus.imem_ack = 1'b1;
                busy = 0;
            end else begin
                bus.imem_ack = 1'b0;
                lat--;
            end
        end
        bus.imem_rdata = mem_word(bus.imem_addr);
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        acks = 0;
    endtask

    // Monitor: samples mid-cycle, between input changes and the next edge.
    bit          prev_reset = 1;
    bit          prev_redirect = 0;
    bit          prev_hold = 0;
    bit          prev_wait = 0;
    logic [18:0] prev_instr, prev_pc, prev_addr;

    always @(negedge clk) begin
        logic [18:0] e;
        if (prev_reset) begin
            check("rst_req", bus.imem_req, 0);
            check("rst_valid", bus.instr_valid, 0);
            check("rst_addr", bus.imem_addr, RESET_PC);
            check("rst_instr", bus.instr, 0);
            check("rst_instr_pc", bus.instr_pc, 0);
        end else begin
            if (prev_redirect) check("valid_after_redirect", bus.instr_valid, 0);
            if (prev_hold) begin
                check("hold_instr", bus.instr, prev_instr);
                check("hold_instr_pc", bus.instr_pc, prev_pc);
            end
            if (prev_wait) begin
                check("req_held", bus.imem_req, 1);
                check("addr_held", bus.imem_addr, prev_addr);
            end
        end

        if (!reset && bus.instr_valid && bus.instr_ready) begin
            deliveries++;
            if (exp_q.size() == 0) begin
                check("unexpected_instr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, e);
                check("instr", bus.instr, mem_word(e));
                exp_q.push_back(tail_pc);
                tail_pc = tail_pc + 19'd1;
            end
        end
        if (!reset && bus.imem_req && bus.imem_ack) acks++;

        prev_reset    = reset;
        prev_redirect = bus.redirect_valid;
        prev_hold     = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid && !reset;
        prev_wait     = bus.imem_req && !bus.imem_ack && !reset;
        prev_instr    = bus.instr;
        prev_pc       = bus.instr_pc;
        prev_addr     = bus.imem_addr;
    end

    initial begin
        int first;
        int cnt;
        int d0;
        bit found;

        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;
        repeat (3) do_reset();

        // Linear fetch with zero-wait memory
        bus.instr_ready = 1'b1;
        lat_mode = 0;
        do_reset();
        first = -1;
        for (int i = 0; i < 16 && first < 0; i++) begin
            step();
            if (bus.instr_valid) first = i;
        end
        check("first_valid_latency", first, 1);
        cnt = 0;
        repeat (10) begin
            step();
            if (bus.instr_valid) cnt++;
        end
        check("throughput", cnt, 10);

        // Backpressure: buffer fills, request stops, head holds
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (8) step();
        check("bp_req_low", bus.imem_req, 0);
        check("bp_acks", acks, 2);
        check("bp_instr", bus.instr, 19'h100);
        check("bp_instr_pc", bus.instr_pc, 0);
        d0 = deliveries;
        bus.instr_ready = 1'b1;
        repeat (6) step();
        check("bp_release", (deliveries - d0) >= 3, 1);

        // Redirect with a slow read in flight
        lat_mode = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (bus.imem_req && bus.imem_addr == 19'd5 && !bus.imem_ack) found = 1;
        end
        check("inflight_found", found, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 19'h40;
        step();
        check("drain_addr", bus.imem_addr, 5);
        cnt = 0;
        while (cnt < 12 && !(bus.imem_req && bus.imem_addr != 19'd5)) begin
            step();
            cnt++;
        end
        check("after_drain_addr", bus.imem_addr, 19'h40);
        d0 = deliveries;
        repeat (20) step();
        check("after_drain_progress", (deliveries - d0) >= 2, 1);

        // Redirect coincident with ack and pop
        lat_mode = 0;
        do_reset();
        repeat (6) step();
        check("coincide_setup", {bus.imem_req, bus.imem_ack, bus.instr_valid}, 3'b111);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 19'h200;
        step();
        check("coincide_valid", bus.instr_valid, 0);
        check("coincide_next_addr", bus.imem_addr, 19'h200);

        // PC wrap
        d0 = deliveries;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 19'h7FFFE;
        repeat (8) step();
        check("wrap_progress", (deliveries - d0) >= 3, 1);

        // Reset mid-stream with a full buffer
        bus.instr_ready = 1'b0;
        repeat (6) step();
        check("full_valid", bus.instr_valid, 1);
        do_reset();
        check("midrst_valid", bus.instr_valid, 0);
        step();
        check("restart_req", bus.imem_req, 1);
        check("restart_addr", bus.imem_addr, RESET_PC);

        // Random traffic
        lat_mode = -1;
        d0 = deliveries;
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = ($urandom_range(0, 3) == 0)
                    ? 19'h7FFFC + 19'($urandom_range(0, 3))
                    : 19'($urandom);
            end
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
        end
        step();
        check("random_progress", (deliveries - d0) > 300, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
